// File: rtl/wb_pkg.sv
// Shared encodings and queue entry type for the writeback/commit stage.
package wb_pkg;

  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_AW = 5;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_LINK = 2'd2;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_BU = 3'd1;
  localparam logic [2:0] LD_B  = 3'd2;
  localparam logic [2:0] LD_HU = 3'd3;
  localparam logic [2:0] LD_H  = 3'd4;

  typedef struct packed {
    logic             live;
    logic [WB_AW-1:0] waddr;
    logic [WB_DW-1:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/wb_load_ext.sv
// Combinational load extender: picks byte/halfword by offset and zero/sign-extends.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [1:0]    off_i,
  input  logic [DW-1:0] word_i,
  input  logic [2:0]    op_i,
  output logic [DW-1:0] ext_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = word_i[{off_i, 3'b000} +: 8];
    half_c = word_i[{off_i[1], 4'b0000} +: 16];
    case (op_i)
      LD_BU:   ext_o = DW'(byte_c);
      LD_B:    ext_o = {{(DW-8){byte_c[7]}}, byte_c};
      LD_HU:   ext_o = DW'(half_c);
      LD_H:    ext_o = {{(DW-16){half_c[15]}}, half_c};
      default: ext_o = word_i;
    endcase
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit: merges main-pipe and queued MDU results onto the single RF write port.
// Define WB_FWD_EN to add the fwd_* youngest-match lookup over live queue entries.
module wb_commit
  import wb_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pipe_valid_i,
  input  logic                       pipe_regwrite_i,
  input  logic [AW-1:0]              pipe_waddr_i,
  input  logic [1:0]                 pipe_sel_i,
  input  logic [DW-1:0]              pipe_aluout_i,
  input  logic [DW-1:0]              pipe_dmout_i,
  input  logic [DW-1:0]              pipe_pc_i,
  input  logic [2:0]                 pipe_load_i,
  input  logic                       mdu_valid_i,
  output logic                       mdu_ready_o,
  input  logic [AW-1:0]              mdu_waddr_i,
  input  logic [DW-1:0]              mdu_wdata_i,
  output logic                       rf_we_o,
  output logic [AW-1:0]              rf_waddr_o,
  output logic [DW-1:0]              rf_wdata_o,
`ifdef WB_FWD_EN
  input  logic [AW-1:0]              fwd_raddr_i,
  output logic                       fwd_hit_o,
  output logic [DW-1:0]              fwd_data_o,
`endif
  output logic [$clog2(DEPTH+1)-1:0] q_count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  wb_entry_t     q_q [DEPTH];
  wb_entry_t     q_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;

  logic [DW-1:0] ld_ext, pipe_res;
  logic          pipe_we, mdu_xfer, mdu_live, q_empty, pop, push;
  wb_entry_t     head_e;

  wb_load_ext #(.DW(DW)) u_load_ext (
    .off_i  (pipe_aluout_i[1:0]),
    .word_i (pipe_dmout_i),
    .op_i   (pipe_load_i),
    .ext_o  (ld_ext)
  );

  always_comb begin
    case (pipe_sel_i)
      SEL_LOAD: pipe_res = ld_ext;
      SEL_LINK: pipe_res = pipe_pc_i + DW'(4);
      default:  pipe_res = pipe_aluout_i;
    endcase
  end

  // mdu_ready depends on registered occupancy only, so a pop cannot feed back into it.
  assign mdu_ready_o = (count_q < CW'(DEPTH));
  assign pipe_we     = pipe_valid_i & pipe_regwrite_i & (pipe_waddr_i != '0);
  assign mdu_xfer    = mdu_valid_i & mdu_ready_o;
  assign mdu_live    = mdu_xfer & (mdu_waddr_i != '0);
  assign q_empty     = (count_q == '0);
  assign head_e      = q_q[head_q];
  assign pop         = !pipe_we && !q_empty;
  assign push        = mdu_live && !(!pipe_we && q_empty)
                       && !(pipe_we && (mdu_waddr_i == pipe_waddr_i));

  // Arbitration, squash and queue update.
  always_comb begin
    q_d        = q_q;
    head_d     = head_q;
    tail_d     = tail_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;

    if (pipe_we) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_waddr_i;
      rf_wdata_d = pipe_res;
    end else if (!q_empty) begin
      rf_we_d = head_e.live;
      if (head_e.live) begin
        rf_waddr_d = AW'(head_e.waddr);
        rf_wdata_d = DW'(head_e.wdata);
      end
    end else if (mdu_live) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = mdu_waddr_i;
      rf_wdata_d = mdu_wdata_i;
    end

    if (pipe_we) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (q_q[i].waddr == WB_AW'(pipe_waddr_i)) q_d[i].live = 1'b0;
      end
    end

    if (pop) head_d = head_q + PW'(1);
    if (push) begin
      q_d[tail_q] = '{live: 1'b1, waddr: WB_AW'(mdu_waddr_i), wdata: WB_DW'(mdu_wdata_i)};
      tail_d      = tail_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) q_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      q_q        <= q_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign q_count_o  = count_q;

`ifdef WB_FWD_EN
  logic [PW-1:0] fwd_idx;

  // Walk oldest to youngest so the last live match wins.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    fwd_idx    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && q_q[fwd_idx].live && (fwd_raddr_i != '0)
          && (q_q[fwd_idx].waddr == WB_AW'(fwd_raddr_i))) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = DW'(q_q[fwd_idx].wdata);
      end
    end
  end
`endif

endmodule
